// File: rtl/uart_defs.sv
// Register map, STATUS/CTRL bit positions and helpers shared by the UART
// transmitter, receiver and receive FIFO.
package uart_defs;

  // Word-select field, mem_addr[3:2]
  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegRsvd2  = 2'd2,
    RegRsvd3  = 2'd3
  } reg_sel_e;

  localparam int unsigned DataValid   = 8;

  localparam int unsigned StatusEmpty  = 8;
  localparam int unsigned StatusFull   = 9;
  localparam int unsigned StatusOvr    = 10;
  localparam int unsigned StatusIrqEn  = 11;
  localparam int unsigned StatusThrLsb = 12;

  localparam int unsigned CtrlClrOvr  = 0;
  localparam int unsigned CtrlFlush   = 1;
  localparam int unsigned CtrlIrqEn   = 11;
  localparam int unsigned CtrlThrLsb  = 12;

  localparam int unsigned ThrWidth = 7;

  // Threshold 0 behaves as 1; anything above the FIFO depth saturates.
  function automatic logic [ThrWidth-1:0] clamp_thr(input logic [ThrWidth-1:0] v,
                                                    input int unsigned depth);
    if (v == '0) return 7'd1;
    if (32'(v) > depth) return 7'(depth);
    return v;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with a PicoRV32-style memory bus: DATA pops on read, STATUS/CTRL
// exposes count/flags and configures the level interrupt.
module uart_rx_fifo
  import uart_defs::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  output logic        irq
);

  localparam int unsigned Depth = 2**DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q, count;
  logic [ThrWidth-1:0] count7, thr_q, new_thr_q;
  logic [31:0]         rdata_q, read_word;
  logic [7:0]          head;
  logic overrun_q, irq_en_q, irq_q, ready_q, armed_q;
  logic pop_pend_q, ctrl_wr_q, clr_ovr_q, flush_q, new_irq_en_q;
  logic empty, full, req, is_read, pop, flush, push, ovr_set, ovr_clr, ctrl_apply;
  reg_sel_e sel;

  logic unused_bits;
  assign unused_bits = ^{mem_instr, mem_addr[31:4], mem_addr[1:0],
                         mem_wdata[31:19], mem_wdata[10:2]};

  assign count  = wr_ptr_q - rd_ptr_q;
  assign count7 = 7'(count);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                  (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);

  // armed_q ensures mem_valid is seen low between transactions
  assign req     = mem_valid & enable & armed_q & ~ready_q;
  assign is_read = (mem_wstrb == 4'b0000);
  assign sel     = reg_sel_e'(mem_addr[3:2]);

  // Side effects of a transaction land in its mem_ready cycle
  assign pop        = ready_q & pop_pend_q;
  assign ctrl_apply = ready_q & ctrl_wr_q;
  assign flush      = ctrl_apply & flush_q;
  assign ovr_clr    = ctrl_apply & clr_ovr_q;
  assign push       = rx_strobe & (~full | pop) & ~flush;
  assign ovr_set    = rx_strobe & full & ~pop & ~flush;

  always_comb begin
    read_word = '0;
    unique case (sel)
      RegData: begin
        if (!empty) begin
          read_word[7:0]      = head;
          read_word[DataValid] = 1'b1;
        end
      end
      RegStatus: begin
        read_word[ThrWidth-1:0]               = count7;
        read_word[StatusEmpty]                = empty;
        read_word[StatusFull]                 = full;
        read_word[StatusOvr]                  = overrun_q;
        read_word[StatusIrqEn]                = irq_en_q;
        read_word[StatusThrLsb +: ThrWidth]   = thr_q;
      end
      default: read_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overrun_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      thr_q        <= 7'd1;
      irq_q        <= 1'b0;
      ready_q      <= 1'b0;
      armed_q      <= 1'b0;
      rdata_q      <= '0;
      pop_pend_q   <= 1'b0;
      ctrl_wr_q    <= 1'b0;
      clr_ovr_q    <= 1'b0;
      flush_q      <= 1'b0;
      new_irq_en_q <= 1'b0;
      new_thr_q    <= 7'd1;
    end else begin
      ready_q <= req;
      if (req) armed_q <= 1'b0;
      else if (!mem_valid) armed_q <= 1'b1;

      if (req) begin
        rdata_q      <= is_read ? read_word : '0;
        pop_pend_q   <= is_read && (sel == RegData) && !empty;
        ctrl_wr_q    <= !is_read && (sel == RegStatus);
        clr_ovr_q    <= mem_wdata[CtrlClrOvr];
        flush_q      <= mem_wdata[CtrlFlush];
        new_irq_en_q <= mem_wdata[CtrlIrqEn];
        new_thr_q    <= clamp_thr(mem_wdata[CtrlThrLsb +: ThrWidth], Depth);
      end

      if (flush) rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;

      if (ovr_set) overrun_q <= 1'b1;
      else if (ovr_clr) overrun_q <= 1'b0;

      if (ctrl_apply) begin
        irq_en_q <= new_irq_en_q;
        thr_q    <= new_thr_q;
      end

      irq_q <= irq_en_q & ((count7 >= thr_q) | overrun_q);
    end
  end

  uart_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata(rx_data),
    .raddr(rd_ptr_q[DEPTH_LOG2-1:0]),
    .rdata(head)
  );

  assign mem_ready = ready_q;
  assign mem_rdata = enable ? rdata_q : '0;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (depth 16): table of bus/push vectors plus
// hand sequences for overrun, coincident push/pop/flush, irq and handshake.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_rdata;
  logic [7:0]  rx_data = '0;
  logic        rx_strobe = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH_LOG2(4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_instr(mem_instr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .rx_data  (rx_data),
    .rx_strobe(rx_strobe),
    .irq      (irq)
  );

  typedef enum int {OpPush, OpRd, OpWr} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  // One bus transaction; optionally pulses rx_strobe during the mem_ready cycle.
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                     input logic strobe_in_ready, input logic [7:0] sbyte,
                     output logic [31:0] rd);
    logic got;
    got = 1'b0;
    mem_addr = addr;
    mem_wstrb = strb;
    mem_wdata = wd;
    mem_valid = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (mem_ready) got = 1'b1;
    end
    rd = mem_rdata;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL bus_timeout: got no mem_ready expected mem_ready at addr 0x%08h", addr);
    end
    mem_valid = 1'b0;
    enable = 1'b0;
    if (strobe_in_ready) begin
      rx_data = sbyte;
      rx_strobe = 1'b1;
    end
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    bus(addr, 4'h0, 32'h0, 1'b0, 8'h00, rd);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    bus(addr, 4'hF, wd, 1'b0, 8'h00, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int pulses;

    vecs.push_back('{OpRd,   32'h4, 32'h0,     32'h0000_1100, "reset_status"});
    vecs.push_back('{OpPush, 32'h0, 32'h41,    32'h0,         "push41"});
    vecs.push_back('{OpPush, 32'h0, 32'h42,    32'h0,         "push42"});
    vecs.push_back('{OpPush, 32'h0, 32'h43,    32'h0,         "push43"});
    vecs.push_back('{OpWr,   32'h0, 32'h7F802, 32'h0,         "data_write"});
    vecs.push_back('{OpRd,   32'h4, 32'h0,     32'h0000_1003, "status_3"});
    vecs.push_back('{OpRd,   32'h0, 32'h0,     32'h0000_0141, "data0"});
    vecs.push_back('{OpRd,   32'h0, 32'h0,     32'h0000_0142, "data1"});
    vecs.push_back('{OpRd,   32'h0, 32'h0,     32'h0000_0143, "data2"});
    vecs.push_back('{OpRd,   32'h0, 32'h0,     32'h0000_0000, "data_empty"});
    vecs.push_back('{OpRd,   32'h4, 32'h0,     32'h0000_1100, "status_empty"});
    vecs.push_back('{OpWr,   32'hC, 32'h7F802, 32'h0,         "rsvd_write"});
    vecs.push_back('{OpRd,   32'h8, 32'h0,     32'h0000_0000, "rsvd8"});
    vecs.push_back('{OpRd,   32'hC, 32'h0,     32'h0000_0000, "rsvdC"});
    vecs.push_back('{OpRd,   32'h4, 32'h0,     32'h0000_1100, "status_after_rsvd"});
    vecs.push_back('{OpWr,   32'h4, 32'h0,     32'h0,         "thr_zero_wr"});
    vecs.push_back('{OpRd,   32'h4, 32'h0,     32'h0000_1100, "thr_zero"});
    vecs.push_back('{OpWr,   32'h4, 32'h7F000, 32'h0,         "thr_sat_wr"});
    vecs.push_back('{OpRd,   32'h4, 32'h0,     32'h0001_0100, "thr_sat"});
    vecs.push_back('{OpWr,   32'h4, 32'h3000,  32'h0,         "thr3_wr"});
    vecs.push_back('{OpRd,   32'h4, 32'h0,     32'h0000_3100, "thr3"});
    vecs.push_back('{OpWr,   32'h4, 32'h1000,  32'h0,         "thr1_wr"});

    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_ready", {31'b0, mem_ready}, 32'h0);

    foreach (vecs[i]) begin
      unique case (vecs[i].op)
        OpPush: push(vecs[i].wdata[7:0]);
        OpRd:   rd_chk(vecs[i].addr, vecs[i].exp, vecs[i].name);
        OpWr:   wr(vecs[i].addr, vecs[i].wdata);
        default: ;
      endcase
    end
    check("rdata_disabled", mem_rdata, 32'h0);

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i <= 16; i++) push(8'(i));
    rd_chk(32'h4, 32'h0000_1610, "full_overrun");
    check("irq_disabled", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 16; i++) rd_chk(32'h0, 32'h100 | 32'(i), "ovf_data");
    rd_chk(32'h4, 32'h0000_1500, "drained_overrun");
    wr(32'h4, 32'h1001);
    rd_chk(32'h4, 32'h0000_1100, "overrun_cleared");

    // Overrun set and clear in the same cycle
    for (int i = 0; i <= 16; i++) push(8'hC0 + 8'(i));
    bus(32'h4, 4'hF, 32'h1001, 1'b1, 8'hEE, rd);
    rd_chk(32'h4, 32'h0000_1610, "ovr_set_wins");
    wr(32'h4, 32'h1003);
    rd_chk(32'h4, 32'h0000_1100, "flush_and_clear");

    // Push coincident with pop while full
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    rd_chk(32'h4, 32'h0000_1210, "full16");
    bus(32'h0, 4'h0, 32'h0, 1'b1, 8'hA5, rd);
    check("pop_push_data", rd, 32'h0000_0180);
    rd_chk(32'h4, 32'h0000_1210, "pop_push_status");
    for (int i = 1; i < 16; i++) rd_chk(32'h0, 32'h180 + 32'(i), "pop_push_order");
    rd_chk(32'h0, 32'h0000_01A5, "pop_push_last");
    rd_chk(32'h4, 32'h0000_1100, "pop_push_empty");

    // Interrupt threshold
    wr(32'h4, 32'h4800);
    rd_chk(32'h4, 32'h0000_4900, "irq_cfg");
    push(8'h61);
    push(8'h62);
    push(8'h63);
    tick();
    check("irq_below", {31'b0, irq}, 32'h0);
    push(8'h64);
    check("irq_latency", {31'b0, irq}, 32'h0);
    tick();
    check("irq_at_thr", {31'b0, irq}, 32'h1);
    rd_chk(32'h0, 32'h0000_0161, "irq_pop");
    tick();
    check("irq_after_pop", {31'b0, irq}, 32'h0);
    for (int i = 2; i <= 4; i++) rd_chk(32'h0, 32'h160 + 32'(i), "irq_drain");
    wr(32'h4, 32'h1000);

    // Flush coincident with push
    for (int i = 1; i <= 5; i++) push(8'h70 + 8'(i));
    rd_chk(32'h4, 32'h0000_1005, "pre_flush");
    bus(32'h4, 4'hF, 32'h1002, 1'b1, 8'h99, rd);
    rd_chk(32'h4, 32'h0000_1100, "flush_wins");

    // mem_valid held for 4 cycles
    push(8'h11);
    push(8'h22);
    pulses = 0;
    mem_addr = 32'h0;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_ready) begin
        pulses++;
        check("held_data", mem_rdata, 32'h0000_0111);
      end
    end
    mem_valid = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (mem_ready) pulses++;
    end
    check("held_pulses", 32'(pulses), 32'd1);
    rd_chk(32'h4, 32'h0000_1001, "held_one_pop");

    // Reset in the middle of a request
    mem_addr = 32'h0;
    mem_valid = 1'b1;
    enable = 1'b1;
    #1;
    resetn = 1'b0;
    tick();
    #2;
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_ready) pulses++;
    end
    check("reset_abort", 32'(pulses), 32'd0);
    mem_valid = 1'b0;
    enable = 1'b0;
    tick();
    rd_chk(32'h4, 32'h0000_1100, "post_reset_status");
    push(8'h5A);
    rd_chk(32'h0, 32'h0000_015A, "post_reset_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
